// File: rtl/uart_rx_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_collector_pkg
// Description : Shared UART definitions: FSM state encoding, 8N1 frame
//               constants and the clocks-per-bit derivation used by both the
//               transmitter and the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_collector_pkg;

    // Frame shape: 8 data bits, 1 stop bit, no parity
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Receiver state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Clock cycles per line bit (integer divide); zero baud yields zero so
    // the elaboration check in the user flags it instead of dividing by zero
    function automatic int bit_cycles(input int clk_freq_hz, input int baud_rate);
        return (baud_rate > 0) ? (clk_freq_hz / baud_rate) : 0;
    endfunction

    // Clock cycles from the start edge to the middle of the start bit
    function automatic int half_cycles(input int clk_freq_hz, input int baud_rate);
        return bit_cycles(clk_freq_hz, baud_rate) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : N-flop synchroniser for an asynchronous input. Every flop
//               resets to 1 so an idle (high) serial line looks idle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] chain;

    generate
        if (STAGES < 2) begin : g_stage_check
            $error("uart_rx_sync: STAGES must be at least 2");
        end
    endgenerate

    // Shift the raw input through the flop chain, oldest sample at the top
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_collector.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_collector
// Description : 8N1 UART receiver. Deserialises the line into bytes, offers
//               them on a valid/ready handshake and flags framing errors and
//               overruns with single-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_collector
    import uart_rx_collector_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 0,
    parameter int BAUD_RATE   = 57600
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int BIT   = bit_cycles(CLK_FREQ_HZ, BAUD_RATE);
    localparam int HALF  = half_cycles(CLK_FREQ_HZ, BAUD_RATE);
    localparam int TW    = $clog2(BIT) + 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [TW-1:0]    HALF_LOAD = TW'(HALF - 1);
    localparam logic [TW-1:0]    BIT_LOAD  = TW'(BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    generate
        if (BIT < 4) begin : g_bit_check
            $error("uart_rx_collector: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
        end
        if (STOP_BITS != 1) begin : g_stop_check
            $error("uart_rx_collector: only one stop bit is supported");
        end
    endgenerate

    logic                 rx_s;
    logic                 rx_prev;
    logic [2:0]           state;
    logic [TW-1:0]        timer;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    logic start_edge;
    logic in_frame;
    logic sample_pt;
    logic deliver;
    logic stop_low;

    uart_rx_sync #(
        .STAGES (2)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_uart_rx),
        .o_sync  (rx_s)
    );

    // A start is a 1->0 transition seen while idle; a prior 1 is required
    assign start_edge = (state == ST_IDLE) && rx_prev && !rx_s;
    assign in_frame   = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign sample_pt  = in_frame && (timer == '0);
    assign deliver    = (state == ST_STOP) && sample_pt && rx_s;
    assign stop_low   = (state == ST_STOP) && sample_pt && !rx_s;

    // Remember the previous synchronised level for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    // Frame sequencing: start check, data bits, stop check, break recovery
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_edge) state <= ST_START;
                ST_START: if (sample_pt) state <= rx_s ? ST_IDLE : ST_DATA;
                ST_DATA:  if (sample_pt && (bit_idx == LAST_IDX)) state <= ST_STOP;
                ST_STOP:  if (sample_pt) state <= rx_s ? ST_IDLE : ST_BREAK;
                ST_BREAK: if (rx_s) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Bit timer: half a bit to the start-bit centre, then a full bit per sample
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer <= '0;
        end else if (start_edge) begin
            timer <= HALF_LOAD;
        end else if (in_frame) begin
            timer <= sample_pt ? BIT_LOAD : (timer - TW'(1));
        end
    end

    // Data capture: LSB arrives first, so shift new bits in at the MSB
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_idx   <= '0;
            shift_reg <= '0;
        end else if (sample_pt && (state == ST_START)) begin
            bit_idx <= '0;
        end else if (sample_pt && (state == ST_DATA)) begin
            bit_idx   <= bit_idx + IDX_W'(1);
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
        end
    end

    // Output holding register with overrun and framing-error pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= stop_low;
            o_overrun   <= 1'b0;
            if (deliver) begin
                if (!o_valid || i_ready) begin
                    o_data  <= shift_reg;
                    o_valid <= 1'b1;
                end else begin
                    // Consumer still holds the previous byte: keep it, drop this one
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_collector
// Description : Self-checking bench for uart_rx_collector with a frame-level
//               reference model, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_collector;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int BIT    = 10;
    localparam int HALF   = 5;
    localparam int CP     = 100;      // clock period in time units

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       line     = 1'b1;
    logic       ready    = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;

    uart_rx_collector #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_uart_rx   (line),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #(CP/2) clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level, cycle-sampled) ----------
    int         cyc = 0;
    bit         m_s1 = 1'b1, m_s2 = 1'b1, m_prev = 1'b1;
    bit         busy = 1'b0, brk = 1'b0;
    int         start_c = 0;
    bit   [7:0] m_byte = '0;
    bit   [7:0] e_data = '0;
    bit         e_valid = 1'b0, e_ferr = 1'b0, e_ovr = 1'b0;

    always @(posedge clk) begin : p_model
        bit r;
        bit dlv;
        int off;
        int k;
        cyc++;
        if (!rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1;
            busy = 1'b0; brk = 1'b0;
            e_data = '0; e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
        end else begin
            r     = m_s2;              // line as seen after two synchroniser flops
            dlv   = 1'b0;
            e_ferr = 1'b0;
            e_ovr  = 1'b0;
            if (busy) begin
                off = cyc - start_c;
                if (off == HALF) begin
                    if (r) busy = 1'b0;            // false start
                end else if (off > HALF && ((off - HALF) % BIT) == 0) begin
                    k = (off - HALF) / BIT;
                    if (k <= 8) begin
                        m_byte[k-1] = r;
                    end else begin
                        busy = 1'b0;
                        if (r) dlv = 1'b1;
                        else begin
                            e_ferr = 1'b1;
                            brk    = 1'b1;
                        end
                    end
                end
            end else if (brk) begin
                if (r) brk = 1'b0;
            end else if (m_prev && !r) begin
                busy    = 1'b1;
                start_c = cyc;
            end
            if (dlv) begin
                if (!e_valid || ready) begin
                    e_data  = m_byte;
                    e_valid = 1'b1;
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (e_valid && ready) begin
                e_valid = 1'b0;
            end
            m_prev = r;
            m_s2   = m_s1;
            m_s1   = line;
        end
    end

    // ---------------- per-cycle compare and event monitor -------------------
    logic [7:0] recv[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         t_fall   = 0;
    int         t_valid  = -1;
    bit         valid_d  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_valid", 32'(o_valid), 32'd0);
            check("reset_data", 32'(o_data), 32'd0);
            check("reset_ferr", 32'(o_frame_err), 32'd0);
            check("reset_ovr", 32'(o_overrun), 32'd0);
        end else begin
            check("valid", 32'(o_valid), 32'(e_valid));
            check("data", 32'(o_data), 32'(e_data));
            check("frame_err", 32'(o_frame_err), 32'(e_ferr));
            check("overrun", 32'(o_overrun), 32'(e_ovr));
            if (o_valid && ready) recv.push_back(o_data);
            if (o_frame_err) ferr_cnt++;
            if (o_overrun) ovr_cnt++;
            if (o_valid && !valid_d && t_valid < 0) t_valid = cyc;
        end
        valid_d = o_valid;
    end

    // ---------------- ready driver ------------------------------------------
    bit rand_ready = 1'b0;
    bit ready_val  = 1'b1;

    initial begin
        forever begin
            @(posedge clk);
            #20;
            ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #25;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_v);
        line   = 1'b0;
        t_fall = cyc;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            #(bit_t);
        end
        line = stop_v;
        #(bit_t);
        if (stop_v) line = 1'b1;
    endtask

    task automatic clear_counts();
        recv.delete();
        ferr_cnt = 0;
        ovr_cnt  = 0;
        t_valid  = -1;
    endtask

    task automatic expect_recv(input string name, input logic [7:0] exp[$]);
        check({name, "_count"}, 32'(recv.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < recv.size(); i++)
            check({name, "_byte"}, 32'(recv[i]), 32'(exp[i]));
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    initial begin
        #(CP * 60000);
        n_bad++;
        $display("FAIL watchdog: run did not complete within the time limit");
        finish_run();
    end

    // ---------------- directed and random scenarios -------------------------
    initial begin
        logic [7:0] q[$];
        idle(3);
        rst_n = 1'b1;
        idle(5);

        // 1: single byte, exact baud, latency pin
        clear_counts();
        send_frame(8'hA5, 1000, 1'b1);
        idle(20);
        q = {}; q.push_back(8'hA5);
        expect_recv("t1", q);
        check("t1_latency", 32'(t_valid - t_fall), 32'd98);
        check("t1_model_data", 32'(e_data), 32'h0A5);
        check("t1_ferr", 32'(ferr_cnt), 32'd0);
        check("t1_ovr", 32'(ovr_cnt), 32'd0);

        // 2: back-to-back frames at nominal, fast and slow baud
        for (int v = 0; v < 3; v++) begin
            int bt;
            bt = (v == 0) ? 1000 : ((v == 1) ? 970 : 1030);
            clear_counts();
            send_frame(8'h00, bt, 1'b1);
            send_frame(8'hFF, bt, 1'b1);
            send_frame(8'h55, bt, 1'b1);
            idle(20);
            q = {}; q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h55);
            expect_recv("t2", q);
            check("t2_ferr", 32'(ferr_cnt), 32'd0);
        end

        // 3: consumer stalled, second byte overruns
        clear_counts();
        ready_val = 1'b0;
        idle(2);
        send_frame(8'h11, 1000, 1'b1);
        send_frame(8'h22, 1000, 1'b1);
        idle(20);
        check("t3_hold_data", 32'(o_data), 32'h11);
        check("t3_hold_valid", 32'(o_valid), 32'd1);
        check("t3_ovr", 32'(ovr_cnt), 32'd1);
        ready_val = 1'b1;
        idle(5);
        check("t3_drained", 32'(o_valid), 32'd0);
        q = {}; q.push_back(8'h11);
        expect_recv("t3", q);

        // 4: stop bit low followed by a held-low line
        clear_counts();
        send_frame(8'h3C, 1000, 1'b0);
        #(30 * CP);
        line = 1'b1;
        idle(20);
        check("t4_ferr", 32'(ferr_cnt), 32'd1);
        check("t4_no_byte", 32'(recv.size()), 32'd0);
        send_frame(8'h3C, 1000, 1'b1);
        idle(20);
        q = {}; q.push_back(8'h3C);
        expect_recv("t4", q);
        check("t4_ferr_after", 32'(ferr_cnt), 32'd1);

        // 5: short glitch is a false start
        clear_counts();
        line = 1'b0;
        #(3 * CP);
        line = 1'b1;
        idle(20);
        check("t5_no_byte", 32'(recv.size()), 32'd0);
        check("t5_ferr", 32'(ferr_cnt), 32'd0);
        send_frame(8'h81, 1000, 1'b1);
        idle(20);
        q = {}; q.push_back(8'h81);
        expect_recv("t5", q);

        // 6: reset during data bit 4 aborts the frame
        clear_counts();
        fork
            send_frame(8'hF0, 1000, 1'b1);
            begin
                #5300;
                rst_n = 1'b0;
                #(2 * CP);
                rst_n = 1'b1;
            end
        join
        idle(20);
        check("t6_no_byte", 32'(recv.size()), 32'd0);
        check("t6_ferr", 32'(ferr_cnt), 32'd0);
        check("t6_ovr", 32'(ovr_cnt), 32'd0);
        send_frame(8'h7E, 1000, 1'b1);
        idle(20);
        q = {}; q.push_back(8'h7E);
        expect_recv("t6", q);

        // Random traffic: random bytes, baud skew, gaps, bad stops and ready
        rand_ready = 1'b1;
        for (int f = 0; f < 25; f++) begin
            int         bt;
            logic [7:0] b;
            logic       sv;
            b = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       bt = 970;
                1:       bt = 1000;
                default: bt = 1030;
            endcase
            sv = ($urandom_range(0, 7) != 0);
            idle(0);
            send_frame(b, bt, sv);
            if (!sv) begin
                #($urandom_range(0, 20) * CP);
                line = 1'b1;
            end
            #($urandom_range(0, 15) * CP);
        end
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        idle(30);

        finish_run();
    end

endmodule
`default_nettype wire
